// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: filtered pad inputs, device-to-host frames into an RX FIFO,
// host-to-device commands with inhibit/ack handling, frame timeout and error reporting.
module ps2_host_ctrl #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned INHIBIT_CYCLES = 4000,
  parameter int unsigned TIMEOUT_CYCLES = 80000,
  parameter int unsigned FIFO_AW        = 3
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [2:0] err_pulse,
  output logic [7:0] err_count,
  output logic       busy
);
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMAX  = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {IDLE, RX, TX_INH, TX_DATA, TX_ACK, TX_WAIT} state_t;

  // Input conditioning; index 0 = clock line, index 1 = data line
  logic [1:0]         sync1_q, sync2_q, filt_q, filt_n;
  logic [1:0][FW-1:0] fcnt_q, fcnt_n;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_n[i] = filt_q[i];
      fcnt_n[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_LEN - 1)) filt_n[i] = sync2_q[i];
        else                                  fcnt_n[i] = fcnt_q[i] + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= {ps2_dat_i, ps2_clk_i};
      sync2_q <= sync1_q;
      filt_q  <= filt_n;
      fcnt_q  <= fcnt_n;
    end
  end

  logic fall_c;
  assign fall_c = filt_q[0] & ~filt_n[0];

  // Controller state
  state_t        state_q, state_n;
  logic [3:0]    bit_cnt_q, bit_cnt_n;
  logic [9:0]    shreg_q, shreg_n, frame_c;
  logic [TW-1:0] timer_q, timer_n;
  logic          clk_oe_q, clk_oe_n, dat_oe_q, dat_oe_n, ack_q, ack_n;
  logic          done_q, done_n, txerr_q, txerr_n, ready_q, ready_n, busy_q, busy_n;
  logic [2:0]    errp_q, errp_n;
  logic [7:0]    errc_q, errc_n;
  logic          push_c, pop_c, full_c, timeout_c;

  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    shreg_n   = shreg_q;
    timer_n   = timer_q;
    clk_oe_n  = 1'b0;
    dat_oe_n  = 1'b0;
    ack_n     = ack_q;
    done_n    = 1'b0;
    txerr_n   = 1'b0;
    errp_n    = 3'b000;
    push_c    = 1'b0;
    timeout_c = 1'b0;
    frame_c   = {filt_q[1], shreg_q[9:1]};
    // Inter-fall watchdog for every state that depends on the device clock
    if (state_q inside {RX, TX_DATA, TX_ACK, TX_WAIT}) begin
      if (fall_c) begin
        timer_n = '0;
      end else begin
        timer_n   = timer_q + TW'(1);
        timeout_c = (timer_q == TW'(TIMEOUT_CYCLES - 1));
      end
    end
    unique case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          state_n  = TX_INH;
          shreg_n  = {1'b0, ~^tx_data, tx_data};
          timer_n  = '0;
          clk_oe_n = 1'b1;
        end else if (fall_c && !filt_q[1]) begin
          state_n   = RX;
          bit_cnt_n = '0;
          timer_n   = '0;
        end
      end
      RX: begin
        if (fall_c) begin
          shreg_n   = frame_c;
          bit_cnt_n = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_n = IDLE;
            if (!(^frame_c[8:0]) || !frame_c[9]) errp_n[0] = 1'b1;
            else if (full_c && !pop_c)           errp_n[1] = 1'b1;
            else                                 push_c    = 1'b1;
          end
        end
      end
      TX_INH: begin
        clk_oe_n = 1'b1;
        timer_n  = timer_q + TW'(1);
        if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_n  = 1'b0;
          dat_oe_n  = 1'b1;
          state_n   = TX_DATA;
          timer_n   = '0;
          bit_cnt_n = '0;
        end
      end
      TX_DATA: begin
        dat_oe_n = dat_oe_q;
        if (fall_c) begin
          bit_cnt_n = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            dat_oe_n = 1'b0;
            state_n  = TX_ACK;
          end else begin
            dat_oe_n = ~shreg_q[bit_cnt_q];
          end
        end
      end
      TX_ACK: begin
        if (fall_c) begin
          ack_n   = filt_q[1];
          state_n = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (filt_q[0] && filt_q[1]) begin
          state_n = IDLE;
          done_n  = 1'b1;
          txerr_n = ack_q;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout_c) begin
      state_n  = IDLE;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      errp_n   = 3'b100;
      push_c   = 1'b0;
      if (state_q != RX) begin
        done_n  = 1'b1;
        txerr_n = 1'b1;
      end
    end
    errc_n  = ((errp_n != 3'b000) && (errc_q != 8'hFF)) ? errc_q + 8'd1 : errc_q;
    ready_n = (state_n == IDLE) && filt_n[0] && filt_n[1];
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      timer_q   <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      txerr_q   <= 1'b0;
      errp_q    <= 3'b000;
      errc_q    <= 8'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shreg_q   <= shreg_n;
      timer_q   <= timer_n;
      clk_oe_q  <= clk_oe_n;
      dat_oe_q  <= dat_oe_n;
      ack_q     <= ack_n;
      done_q    <= done_n;
      txerr_q   <= txerr_n;
      errp_q    <= errp_n;
      errc_q    <= errc_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
    end
  end

  // RX FIFO; head is read combinationally so rx_data is valid with rx_valid
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;

  assign rx_valid = (count_q != '0);
  assign pop_c    = rx_valid && rx_ready;
  assign full_c   = (count_q == CW'(DEPTH));
  assign rx_data  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= frame_c[7:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      unique case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = ready_q;
  assign tx_done    = done_q;
  assign tx_err     = txerr_q;
  assign err_pulse  = errp_q;
  assign err_count  = errc_q;
  assign busy       = busy_q;
endmodule
